// File: rtl/datapath_core.sv
// Single-cycle 64-bit datapath: register file, ALU with flags, PC, instruction ROM/IR and data RAM.
// Defining DATAPATH_CORE_RAM_EN builds in the data RAM; otherwise RAM reads return 0 and MW is ignored.
module datapath_core (
    input  logic        clk,
    input  logic        rst,
    input  logic        AS,
    input  logic [2:0]  DS,
    input  logic [1:0]  PS,
    input  logic        PC_Sel,
    input  logic        K_Sel,
    input  logic        IL,
    input  logic        SL,
    input  logic [4:0]  FS,
    input  logic        C0,
    input  logic        MW,
    input  logic        RW,
    input  logic [4:0]  DA,
    input  logic [4:0]  SA,
    input  logic [4:0]  SB,
    input  logic [63:0] K,
    input  logic [63:0] CU,
    output logic [3:0]  SF,
    output logic [31:0] IR_Out
);
    localparam int unsigned XLEN      = 64;
    localparam int unsigned ILEN      = 32;
    localparam int unsigned NREG      = 32;
    localparam int unsigned RAM_DEPTH = 256;

    localparam logic [4:0] ZERO_REG = 5'd31;

    logic [XLEN-1:0] regs [NREG];
    logic [ILEN-1:0] pc;
    logic [ILEN-1:0] ir;
    logic [3:0]      flags;

    logic [XLEN-1:0] rd_a, rd_b;
    logic [XLEN-1:0] a_bus, b_bus;
    logic [XLEN-1:0] a_op, b_op;
    logic [XLEN:0]   sum;
    logic [XLEN-1:0] alu_res;
    logic            add_c, add_v;
    logic [XLEN-1:0] ram_rd;
    logic [XLEN-1:0] d_bus;
    logic [ILEN-1:0] rom_word;
    logic [ILEN-1:0] pc_plus4;
    logic [ILEN-1:0] br_target;
    logic [ILEN-1:0] pc_next;

    logic [ILEN-1:0] PC_out;
    logic [XLEN-1:0] r0, r1, r2, r3, r4, r5, r6, r7;

    // X31 is hardwired to zero on both read ports
    assign rd_a = (SA == ZERO_REG) ? '0 : regs[SA];
    assign rd_b = (SB == ZERO_REG) ? '0 : regs[SB];

    assign a_bus = AS ? rd_a : XLEN'(pc);
    assign b_bus = K_Sel ? K : rd_b;

    // ALU with optional operand inversion; only ADD produces carry/overflow
    always_comb begin
        a_op    = FS[0] ? ~a_bus : a_bus;
        b_op    = FS[1] ? ~b_bus : b_bus;
        sum     = {1'b0, a_op} + {1'b0, b_op} + (XLEN+1)'(C0);
        alu_res = '0;
        add_c   = 1'b0;
        add_v   = 1'b0;
        case (FS[4:2])
            3'b000: alu_res = a_op & b_op;
            3'b001: alu_res = a_op | b_op;
            3'b010: begin
                alu_res = sum[XLEN-1:0];
                add_c   = sum[XLEN];
                add_v   = (a_op[XLEN-1] == b_op[XLEN-1]) && (sum[XLEN-1] != a_op[XLEN-1]);
            end
            3'b011: alu_res = a_op ^ b_op;
            3'b100: alu_res = a_op << b_op[5:0];
            3'b101: alu_res = a_op >> b_op[5:0];
            default: alu_res = '0;
        endcase
    end

    // Instruction ROM: two boot words, remainder zero
    always_comb begin
        rom_word = '0;
        case (pc[7:2])
            6'd0:    rom_word = 32'h9100_1FE2;
            6'd1:    rom_word = 32'h9100_3843;
            default: rom_word = '0;
        endcase
    end

`ifdef DATAPATH_CORE_RAM_EN
    logic [XLEN-1:0] ram [RAM_DEPTH];
    logic [7:0]      ram_addr;

    assign ram_addr = alu_res[10:3];
    assign ram_rd   = ram[ram_addr];

    // RAM contents survive reset; only the write strobe is blocked
    always_ff @(posedge clk) begin
        if (rst && MW) begin
            ram[ram_addr] <= rd_b;
        end
    end
`else
    logic unused_mw;
    assign unused_mw = MW;
    assign ram_rd    = '0;
`endif

    always_comb begin
        d_bus = '0;
        case (DS)
            3'b000:  d_bus = alu_res;
            3'b001:  d_bus = ram_rd;
            3'b010:  d_bus = XLEN'(pc_plus4);
            3'b011:  d_bus = XLEN'(rom_word);
            3'b100:  d_bus = CU;
            default: d_bus = '0;
        endcase
    end

    assign pc_plus4  = pc + 32'd4;
    assign br_target = PC_Sel ? (pc + ILEN'(K << 2)) : a_bus[ILEN-1:0];

    always_comb begin
        pc_next = pc;
        case (PS)
            2'b01:   pc_next = pc_plus4;
            2'b10:   pc_next = br_target;
            default: pc_next = pc;
        endcase
    end

    // Architectural state; IR fetch and PC update both see the pre-edge PC
    always_ff @(posedge clk) begin
        if (!rst) begin
            pc    <= '0;
            ir    <= '0;
            flags <= '0;
            regs  <= '{default: '0};
        end else begin
            pc <= pc_next;
            if (IL) begin
                ir <= rom_word;
            end
            if (SL) begin
                flags <= {add_v, add_c, alu_res[XLEN-1], (alu_res == '0)};
            end
            if (RW && (DA != ZERO_REG)) begin
                regs[DA] <= d_bus;
            end
        end
    end

    assign SF     = flags;
    assign IR_Out = ir;

    assign PC_out = pc;
    assign r0     = regs[0];
    assign r1     = regs[1];
    assign r2     = regs[2];
    assign r3     = regs[3];
    assign r4     = regs[4];
    assign r5     = regs[5];
    assign r6     = regs[6];
    assign r7     = regs[7];

    logic unused_probe;
    assign unused_probe = ^{PC_out, r0, r1, r2, r3, r4, r5, r6, r7};

endmodule

// File: tb/tb_datapath_core.sv
// Self-checking bench for datapath_core: directed scenarios plus random cycles against an ISA-level model.
module tb_datapath_core;
    logic        clk;
    logic        rst;
    logic        AS;
    logic [2:0]  DS;
    logic [1:0]  PS;
    logic        PC_Sel;
    logic        K_Sel;
    logic        IL;
    logic        SL;
    logic [4:0]  FS;
    logic        C0;
    logic        MW;
    logic        RW;
    logic [4:0]  DA;
    logic [4:0]  SA;
    logic [4:0]  SB;
    logic [63:0] K;
    logic [63:0] CU;
    logic [3:0]  SF;
    logic [31:0] IR_Out;

    int n_checks = 0;
    int n_fail   = 0;

    logic [63:0] m_x [32];
    logic [31:0] m_pc;
    logic [31:0] m_ir;
    logic [3:0]  m_sf;
    logic [63:0] m_ram [int];

    datapath_core dut (
        .clk(clk), .rst(rst), .AS(AS), .DS(DS), .PS(PS), .PC_Sel(PC_Sel),
        .K_Sel(K_Sel), .IL(IL), .SL(SL), .FS(FS), .C0(C0), .MW(MW), .RW(RW),
        .DA(DA), .SA(SA), .SB(SB), .K(K), .CU(CU), .SF(SF), .IR_Out(IR_Out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [63:0] m_rd(input logic [4:0] i);
        return (i == 5'd31) ? 64'd0 : m_x[i];
    endfunction

    function automatic logic [31:0] m_rom(input logic [31:0] addr);
        int unsigned word;
        word = addr[7:2];
        if (word == 0) return 32'h91001FE2;
        if (word == 1) return 32'h91003843;
        return 32'd0;
    endfunction

    function automatic logic [63:0] probe(input int i);
        case (i)
            0: return dut.r0;
            1: return dut.r1;
            2: return dut.r2;
            3: return dut.r3;
            4: return dut.r4;
            5: return dut.r5;
            6: return dut.r6;
            default: return dut.r7;
        endcase
    endfunction

    task automatic idle();
        rst = 1'b1; AS = 1'b1; DS = 3'd0; PS = 2'd0; PC_Sel = 1'b0; K_Sel = 1'b0;
        IL = 1'b0; SL = 1'b0; FS = 5'b01000; C0 = 1'b0; MW = 1'b0; RW = 1'b0;
        DA = 5'd31; SA = 5'd31; SB = 5'd31; K = 64'd0; CU = 64'd0;
    endtask

    // Advance the model by one instruction-level step, then clock the DUT
    task automatic cycle();
        logic [63:0] a, b, res, dbus, st_data;
        logic [64:0] wide;
        logic [65:0] ws;
        logic        c, v;
        logic [31:0] npc, nir;
        a = AS ? m_rd(SA) : {32'd0, m_pc};
        b = K_Sel ? K : m_rd(SB);
        st_data = m_rd(SB);
        if (FS[0]) a = ~a;
        if (FS[1]) b = ~b;
        res = 64'd0; c = 1'b0; v = 1'b0;
        case (FS[4:2])
            3'd0: res = a & b;
            3'd1: res = a | b;
            3'd2: begin
                wide = {1'b0, a} + {1'b0, b} + 65'(C0);
                res  = wide[63:0];
                c    = wide[64];
                ws   = {{2{a[63]}}, a} + {{2{b[63]}}, b} + 66'(C0);
                v    = ws[64] ^ ws[63];
            end
            3'd3: res = a ^ b;
            3'd4: res = a << b[5:0];
            3'd5: res = a >> b[5:0];
            default: res = 64'd0;
        endcase
        case (DS)
            3'd0: dbus = res;
`ifdef DATAPATH_CORE_RAM_EN
            3'd1: dbus = m_ram.exists(int'(res[10:3])) ? m_ram[int'(res[10:3])] : 64'bx;
`else
            3'd1: dbus = 64'd0;
`endif
            3'd2: dbus = {32'd0, m_pc + 32'd4};
            3'd3: dbus = {32'd0, m_rom(m_pc)};
            3'd4: dbus = CU;
            default: dbus = 64'd0;
        endcase
        npc = m_pc;
        if (PS == 2'd1) npc = m_pc + 32'd4;
        if (PS == 2'd2) npc = PC_Sel ? m_pc + K[29:0] * 32'd4 : a[31:0] ^ (FS[0] ? 32'hFFFFFFFF : 32'd0);
        nir = IL ? m_rom(m_pc) : m_ir;
        if (!rst) begin
            m_pc = 32'd0; m_ir = 32'd0; m_sf = 4'd0;
            for (int i = 0; i < 32; i++) m_x[i] = 64'd0;
        end else begin
`ifdef DATAPATH_CORE_RAM_EN
            if (MW) m_ram[int'(res[10:3])] = st_data;
`endif
            if (RW && DA != 5'd31) m_x[DA] = dbus;
            if (SL) m_sf = {v, c, res[63], res == 64'd0};
            m_ir = nir;
            m_pc = npc;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        idle(); rst = 1'b0; cycle();
        n_checks++; if (dut.PC_out !== 32'd0) begin n_fail++; $display("FAIL reset_pc: got %h want 0", dut.PC_out); end
        n_checks++; if (IR_Out !== 32'd0) begin n_fail++; $display("FAIL reset_ir: got %h want 0", IR_Out); end
        n_checks++; if (SF !== 4'd0) begin n_fail++; $display("FAIL reset_sf: got %b want 0000", SF); end
        for (int i = 0; i < 8; i++) begin
            n_checks++;
            if (probe(i) !== 64'd0) begin n_fail++; $display("FAIL reset_r%0d: got %h want 0", i, probe(i)); end
        end
    endtask

    task automatic test_fetch();
        idle(); IL = 1'b1; PS = 2'd1; cycle();
        n_checks++; if (IR_Out !== 32'h91001FE2) begin n_fail++; $display("FAIL fetch_ir: got %h want 91001fe2", IR_Out); end
        n_checks++; if (dut.PC_out !== 32'd4) begin n_fail++; $display("FAIL fetch_pc: got %h want 4", dut.PC_out); end
    endtask

    task automatic test_addi();
        idle(); K = 64'd7; K_Sel = 1'b1; SA = 5'd31; DA = 5'd2; RW = 1'b1; cycle();
        n_checks++; if (dut.r2 !== 64'd7) begin n_fail++; $display("FAIL addi_x2: got %h want 7", dut.r2); end
        n_checks++; if (dut.PC_out !== 32'd4) begin n_fail++; $display("FAIL addi_x2_pc: got %h want 4", dut.PC_out); end
        idle(); IL = 1'b1; PS = 2'd1; cycle();
        n_checks++; if (IR_Out !== 32'h91003843) begin n_fail++; $display("FAIL fetch2_ir: got %h want 91003843", IR_Out); end
        idle(); K = 64'd14; K_Sel = 1'b1; SA = 5'd2; DA = 5'd3; RW = 1'b1; PS = 2'd1; cycle();
        n_checks++; if (dut.r3 !== 64'd21) begin n_fail++; $display("FAIL addi_x3: got %h want 21", dut.r3); end
        n_checks++; if (dut.PC_out !== 32'd12) begin n_fail++; $display("FAIL addi_x3_pc: got %h want 12", dut.PC_out); end
        n_checks++; if (IR_Out !== 32'h91003843) begin n_fail++; $display("FAIL ir_hold: got %h want 91003843", IR_Out); end
    endtask

    task automatic test_flags();
        idle(); SL = 1'b1; cycle();
        n_checks++; if (SF !== 4'b0001) begin n_fail++; $display("FAIL flag_zero: got %b want 0001", SF); end
        idle(); DS = 3'd4; CU = 64'h7FFF_FFFF_FFFF_FFFF; DA = 5'd2; RW = 1'b1; cycle();
        n_checks++; if (SF !== 4'b0001) begin n_fail++; $display("FAIL flag_hold: got %b want 0001", SF); end
        idle(); SA = 5'd2; K = 64'd1; K_Sel = 1'b1; SL = 1'b1; cycle();
        n_checks++; if (SF !== 4'b1010) begin n_fail++; $display("FAIL flag_ovf: got %b want 1010", SF); end
        idle(); DS = 3'd4; CU = '1; DA = 5'd2; RW = 1'b1; cycle();
        idle(); SA = 5'd2; K = 64'd1; K_Sel = 1'b1; SL = 1'b1; cycle();
        n_checks++; if (SF !== 4'b0101) begin n_fail++; $display("FAIL flag_carry: got %b want 0101", SF); end
    endtask

    task automatic test_x31_and_reset();
        idle(); RW = 1'b1; DA = 5'd31; DS = 3'd4; CU = 64'd5; cycle();
        idle(); SA = 5'd31; K_Sel = 1'b1; K = 64'd0; DA = 5'd4; RW = 1'b1; SL = 1'b1; cycle();
        n_checks++; if (dut.r4 !== 64'd0) begin n_fail++; $display("FAIL x31_read: got %h want 0", dut.r4); end
        n_checks++; if (SF !== 4'b0001) begin n_fail++; $display("FAIL x31_flags: got %b want 0001", SF); end
        idle(); rst = 1'b0; RW = 1'b1; DA = 5'd2; DS = 3'd4; CU = 64'd9; IL = 1'b1; PS = 2'd1; SL = 1'b1; cycle();
        n_checks++; if (dut.PC_out !== 32'd0) begin n_fail++; $display("FAIL midreset_pc: got %h want 0", dut.PC_out); end
        n_checks++; if (dut.r2 !== 64'd0) begin n_fail++; $display("FAIL midreset_r2: got %h want 0", dut.r2); end
        n_checks++; if ({IR_Out, SF} !== 36'd0) begin n_fail++; $display("FAIL midreset_ir_sf: got %h want 0", {IR_Out, SF}); end
    endtask

    task automatic test_pc_ops();
        idle(); PS = 2'd2; PC_Sel = 1'b1; K = 64'd3; cycle();
        n_checks++; if (dut.PC_out !== 32'd12) begin n_fail++; $display("FAIL branch_k: got %h want 12", dut.PC_out); end
        idle(); PS = 2'd3; DS = 3'd2; DA = 5'd5; RW = 1'b1; cycle();
        n_checks++; if ({dut.PC_out, dut.r5} !== {32'd12, 64'd16}) begin n_fail++; $display("FAIL hold_pc4: got %h/%h want 12/16", dut.PC_out, dut.r5); end
        idle(); DS = 3'd4; CU = 64'd4; DA = 5'd6; RW = 1'b1; cycle();
        idle(); PS = 2'd2; SA = 5'd6; cycle();
        idle(); DS = 3'd3; DA = 5'd7; RW = 1'b1; cycle();
        n_checks++; if ({dut.PC_out, dut.r7} !== {32'd4, 64'h91003843}) begin n_fail++; $display("FAIL branch_a_rom: got %h/%h want 4/91003843", dut.PC_out, dut.r7); end
        idle(); DS = 3'd4; CU = 64'hABCD_0000_FFFF_FFFC; DA = 5'd6; RW = 1'b1; cycle();
        idle(); PS = 2'd2; SA = 5'd6; cycle();
        n_checks++; if (dut.PC_out !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL branch_trunc: got %h want fffffffc", dut.PC_out); end
        idle(); PS = 2'd1; cycle();
        n_checks++; if (dut.PC_out !== 32'd0) begin n_fail++; $display("FAIL pc_wrap: got %h want 0", dut.PC_out); end
        idle(); DS = 3'd4; CU = 64'h1234; DA = 5'd1; RW = 1'b1; cycle();
`ifdef DATAPATH_CORE_RAM_EN
        idle(); MW = 1'b1; SA = 5'd31; K_Sel = 1'b1; K = 64'd40; SB = 5'd6; cycle();
        idle(); DS = 3'd1; SA = 5'd31; K_Sel = 1'b1; K = 64'd40; DA = 5'd1; RW = 1'b1; cycle();
        n_checks++; if (dut.r1 !== 64'hABCD_0000_FFFF_FFFC) begin n_fail++; $display("FAIL ram_rd: got %h want abcd0000fffffffc", dut.r1); end
`else
        idle(); DS = 3'd1; MW = 1'b1; DA = 5'd1; RW = 1'b1; cycle();
        n_checks++; if (dut.r1 !== 64'd0) begin n_fail++; $display("FAIL noram_rd: got %h want 0", dut.r1); end
`endif
    endtask

    function automatic logic [4:0] pick_reg();
        return ($urandom_range(0, 8) == 8) ? 5'd31 : 5'($urandom_range(0, 7));
    endfunction

    function automatic logic [63:0] pick_val();
        case ($urandom_range(0, 4))
            0: return 64'd0;
            1: return '1;
            2: return 64'h7FFF_FFFF_FFFF_FFFF;
            3: return 64'($urandom_range(0, 70));
            default: return {$urandom, $urandom};
        endcase
    endfunction

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            rst = ($urandom_range(0, 31) != 0);
            AS = 1'($urandom); DS = 3'($urandom); PS = 2'($urandom); PC_Sel = 1'($urandom);
            K_Sel = 1'($urandom); IL = 1'($urandom); SL = 1'($urandom); FS = 5'($urandom);
            C0 = 1'($urandom); MW = 1'($urandom); RW = 1'($urandom);
            DA = pick_reg(); SA = pick_reg(); SB = pick_reg(); K = pick_val(); CU = pick_val();
`ifdef DATAPATH_CORE_RAM_EN
            if (DS == 3'd1) DS = 3'd0;
`endif
            cycle();
            n_checks++;
            if ({dut.PC_out, IR_Out, SF} !== {m_pc, m_ir, m_sf}) begin
                n_fail++;
                $display("FAIL rand_state[%0d]: got pc=%h ir=%h sf=%b want pc=%h ir=%h sf=%b",
                         n, dut.PC_out, IR_Out, SF, m_pc, m_ir, m_sf);
            end
            for (int i = 0; i < 8; i++) begin
                n_checks++;
                if (probe(i) !== m_x[i]) begin
                    n_fail++;
                    $display("FAIL rand_r%0d[%0d]: got %h want %h", i, n, probe(i), m_x[i]);
                end
            end
        end
    endtask

    initial begin
        idle();
        test_reset();
        test_fetch();
        test_addi();
        test_flags();
        test_x31_and_reset();
        test_pc_ops();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
